// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Runs the clock inhibit, start bit, 8 data bits (LSB first), odd parity and
// stop bit, then checks the device ACK. Both pads are open-drain: an OE of 1
// pulls the line low.
// Optional build macro PS2_TX_TIMEOUT_EN adds a watchdog that aborts with ERROR
// when the device stops clocking for TIMEOUT_CYCLES cycles.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | pads released, waiting for WRITE
// S_INHIBIT   | clock held low for INHIBIT_CYCLES, then start bit driven
// S_SEND      | one bit driven per device clock fall (data, parity, stop)
// S_ACK       | sample the device ACK on the 11th clock fall
// S_WAIT_IDLE | wait for both lines high, then pulse DONE or ERROR
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  input  logic [7:0] DATA,
  input  logic       WRITE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYCLES);

`ifdef PS2_TX_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [3:0]    n_q, n_n;
  logic [7:0]    data_q, data_n;
  logic          par_q, par_n;
  logic          ack_ok_q, ack_ok_n;
  logic          clk_oe_n, data_oe_n, busy_n, done_n, error_n;

  logic [7:0]    filt_q;
  logic          clk_filt_q, clk_filt_d;
  logic          ps2_data_q;
  logic          clk_fall;
  logic          tx_bit;
  logic          timed_out;

  // Pad conditioning: data registered once, clock through an 8-sample
  // all-equal filter with hysteresis, plus a delayed copy for edge detect.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      filt_q     <= 8'hFF;
      clk_filt_q <= 1'b1;
      clk_filt_d <= 1'b1;
      ps2_data_q <= 1'b1;
    end else begin
      filt_q     <= {filt_q[6:0], PS2_CLK_IN};
      if (filt_q == 8'hFF)
        clk_filt_q <= 1'b1;
      else if (filt_q == 8'h00)
        clk_filt_q <= 1'b0;
      clk_filt_d <= clk_filt_q;
      ps2_data_q <= PS2_DATA_IN;
    end
  end

  assign clk_fall = clk_filt_d & ~clk_filt_q;

  // State, counters and registered pad/status outputs; async reset releases pads.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      ack_ok_q    <= 1'b0;
      PS2_CLK_OE  <= 1'b0;
      PS2_DATA_OE <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ERROR       <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      n_q         <= n_n;
      data_q      <= data_n;
      par_q       <= par_n;
      ack_ok_q    <= ack_ok_n;
      PS2_CLK_OE  <= clk_oe_n;
      PS2_DATA_OE <= data_oe_n;
      BUSY        <= busy_n;
      DONE        <= done_n;
      ERROR       <= error_n;
    end
  end

  // Next-state and next-output logic for the request/frame/ACK sequence.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    n_n       = n_q;
    data_n    = data_q;
    par_n     = par_q;
    ack_ok_n  = ack_ok_q;
    clk_oe_n  = PS2_CLK_OE;
    data_oe_n = PS2_DATA_OE;
    busy_n    = BUSY;
    done_n    = 1'b0;
    error_n   = 1'b0;
    timed_out = WD_EN && (cnt_q == '0);

    // Bit for index n: data LSB first, then parity, then stop (released).
    if (n_q < 4'd8)
      tx_bit = data_q[n_q[2:0]];
    else if (n_q == 4'd8)
      tx_bit = par_q;
    else
      tx_bit = 1'b1;

    case (state_q)
      S_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (WRITE) begin
          data_n   = DATA;
          par_n    = ~^DATA;
          busy_n   = 1'b1;
          clk_oe_n = 1'b1;
          cnt_n    = INH_LOAD;
          state_n  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == '0) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          n_n       = 4'd0;
          cnt_n     = TO_LOAD;
          state_n   = S_SEND;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      S_SEND: begin
        if (clk_fall) begin
          data_oe_n = ~tx_bit;
          n_n       = (n_q >= 4'd10) ? 4'd10 : n_q + 4'd1;
          cnt_n     = TO_LOAD;
          if (n_q == 4'd9)
            state_n = S_ACK;
        end else if (timed_out) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          error_n   = 1'b1;
          busy_n    = 1'b0;
          state_n   = S_IDLE;
        end else if (WD_EN) begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      S_ACK: begin
        if (clk_fall) begin
          ack_ok_n = ~ps2_data_q;
          cnt_n    = TO_LOAD;
          state_n  = S_WAIT_IDLE;
        end else if (timed_out) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          error_n   = 1'b1;
          busy_n    = 1'b0;
          state_n   = S_IDLE;
        end else if (WD_EN) begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      S_WAIT_IDLE: begin
        if (clk_filt_q && ps2_data_q) begin
          done_n  = ack_ok_q;
          error_n = ~ack_ok_q;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else if (clk_fall) begin
          cnt_n = TO_LOAD;
        end else if (timed_out) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          error_n   = 1'b1;
          busy_n    = 1'b0;
          state_n   = S_IDLE;
        end else if (WD_EN) begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      default: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        busy_n    = 1'b0;
        state_n   = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// captured line bits are compared with a byte/parity reference built from the
// frame format. Covers reset, fixed and random bytes, missing ACK, ignored
// WRITE while busy, mid-frame reset and (with PS2_TX_TIMEOUT_EN) the watchdog.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int TO   = 300;
  localparam int HALF = 30;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       WRITE = 1'b0;
  logic [7:0] DATA = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERROR;
  wire        clk_pad  = dev_clk & ~PS2_CLK_OE;
  wire        data_pad = dev_data & ~PS2_DATA_OE;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .nRESET(nRESET),
    .PS2_CLK_IN(clk_pad), .PS2_DATA_IN(data_pad),
    .PS2_CLK_OE(PS2_CLK_OE), .PS2_DATA_OE(PS2_DATA_OE),
    .DATA(DATA), .WRITE(WRITE),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (DONE === 1'b1) done_cnt++;
    if (ERROR === 1'b1) err_cnt++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Line bits the device should see on rising edges 1..10: data LSB first,
  // odd parity, stop.
  function automatic logic [9:0] frame_model(input logic [7:0] d);
    logic p;
    p = (($countones(d) % 2) == 0);
    return {1'b1, p, d};
  endfunction

  task automatic run_frame(input logic [7:0] d, input bit ack_low, input bit glitch,
                           input int rst_at, input bit exp_done, input bit exp_err,
                           output logic [9:0] got);
    int hi, w, d0, e0;
    got = '0;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge CLK);
    DATA = d;
    WRITE = 1'b1;
    @(negedge CLK);
    WRITE = 1'b0;
    DATA = ~d;
    check("clk_oe_at_t1", PS2_CLK_OE, 1);
    check("busy_at_t1", BUSY, 1);
    hi = 0;
    while (PS2_CLK_OE === 1'b1 && hi < INH + 5) begin
      hi++;
      @(negedge CLK);
      WRITE = glitch && (hi == 3);
    end
    WRITE = 1'b0;
    check("inhibit_len", hi, INH);
    check("start_bit_with_clk_release", PS2_DATA_OE, 1);
    for (int i = 0; i < 11; i++) begin
      repeat (HALF) @(negedge CLK);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLK);
      dev_clk = 1'b1;
      if (i < 10) got[i] = data_pad;
      if (i == 9) dev_data = ~ack_low;
      if (i == 10) dev_data = 1'b1;
      if (glitch && i == 3) begin
        WRITE = 1'b1;
        @(negedge CLK);
        WRITE = 1'b0;
      end
      if (i + 1 == rst_at) begin
        #2 nRESET = 1'b0;
        #1;
        check("rst_clk_oe", PS2_CLK_OE, 0);
        check("rst_data_oe", PS2_DATA_OE, 0);
        check("rst_busy", BUSY, 0);
        dev_clk = 1'b1;
        dev_data = 1'b1;
        repeat (5) @(negedge CLK);
        nRESET = 1'b1;
        repeat (20) @(negedge CLK);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_error", err_cnt - e0, 0);
        return;
      end
    end
    w = 0;
    while (BUSY === 1'b1 && w < 200) begin
      w++;
      @(negedge CLK);
    end
    repeat (3) @(negedge CLK);
    check("busy_after", BUSY, 0);
    check("frame_bits", got, frame_model(d));
    check("done_pulses", done_cnt - d0, exp_done);
    check("error_pulses", err_cnt - e0, exp_err);
    check("clk_oe_after", PS2_CLK_OE, 0);
    check("data_oe_after", PS2_DATA_OE, 0);
    repeat (10) @(negedge CLK);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         ack_low;
    bit         glitch;
    int         rst_at;
    bit         exp_par;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [9:0] got;
    logic [7:0] rd;
    bit         ra;
    int         hi, k;

    vecs[0] = '{8'hF4, 1, 0, -1, 0, 1, 0};
    vecs[1] = '{8'h00, 1, 0, -1, 1, 1, 0};
    vecs[2] = '{8'hFF, 1, 0, -1, 1, 1, 0};
    vecs[3] = '{8'hED, 1, 0, -1, 1, 1, 0};
    vecs[4] = '{8'hFF, 0, 0, -1, 1, 0, 1};
    vecs[5] = '{8'hA5, 1, 1, -1, 1, 1, 0};
    vecs[6] = '{8'hF4, 1, 0,  5, 0, 0, 0};
    vecs[7] = '{8'hF4, 1, 0, -1, 0, 1, 0};

    repeat (3) @(negedge CLK);
    check("reset_clk_oe", PS2_CLK_OE, 0);
    check("reset_data_oe", PS2_DATA_OE, 0);
    check("reset_busy", BUSY, 0);
    nRESET = 1'b1;
    repeat (12) @(negedge CLK);
    check("idle_done", DONE, 0);
    check("idle_error", ERROR, 0);
    check("idle_busy", BUSY, 0);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].d, vecs[i].ack_low, vecs[i].glitch, vecs[i].rst_at,
                vecs[i].exp_done, vecs[i].exp_err, got);
      if (vecs[i].rst_at < 0)
        check("table_parity_bit", got[8], vecs[i].exp_par);
    end

    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom);
      ra = 1'($urandom_range(0, 1));
      run_frame(rd, ra, 1'b0, -1, ra, ~ra, got);
    end

`ifdef PS2_TX_TIMEOUT_EN
    @(negedge CLK);
    DATA = 8'h3C;
    WRITE = 1'b1;
    @(negedge CLK);
    WRITE = 1'b0;
    hi = 0;
    while (PS2_CLK_OE === 1'b1 && hi < INH + 5) begin
      hi++;
      @(negedge CLK);
    end
    k = 0;
    while (ERROR !== 1'b1 && k < TO + 10) begin
      k++;
      @(negedge CLK);
    end
    check("timeout_latency", k, TO + 1);
    check("timeout_clk_oe", PS2_CLK_OE, 0);
    check("timeout_data_oe", PS2_DATA_OE, 0);
    check("timeout_busy", BUSY, 0);
    repeat (10) @(negedge CLK);
`else
    hi = 0;
    k = 0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
